lv1b_req_gen: RTL and testbench
===============================

LV1B_REQ_GEN -- requirements
Module: lv1b_req_gen

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_live  input  1  run-live level; low forces IDLE; rising edge clears counters.
REQ-004 in_ena  input  1  global enable; sampled only on lv1a acceptance.
REQ-005 in_lv1a  input  1  level-1A accept pulse, one cycle.
REQ-006 in_clus_valid  input  1  one-cycle pulse per cluster found by the cluster finder.
REQ-007 user_window  input  8  cluster collection window length in cycles.
REQ-008 user_holdoff  input  16  busy cycles after each issued request.
REQ-009 user_ena  input  1  block enable register.
REQ-010 out_lv1a  output  1  one-cycle lv1a echo, time-aligned with out_lv1b_req.
REQ-011 out_lv1b_req  output  1  one-cycle lv1b request pulse.
REQ-012 out_nclus  output  4  cluster count for the request; valid only while out_lv1b_req is high, else 0.
REQ-013 out_busy  output  1  high in COLLECT, ISSUE and HOLD.
REQ-014 req_cnt  output  32  issued requests since the last live rising edge.
REQ-015 reject_cnt  output  32  lv1a pulses rejected while busy (see REQ-032).

Function
REQ-016 FSM states: IDLE, COLLECT, ISSUE, HOLD; single registered state vector.
REQ-017 IDLE->COLLECT when in_lv1a=1, in_live=1, in_ena=1, user_ena=1 in the same cycle T; the cluster counter loads 0 at T.
REQ-018 COLLECT counts in_clus_valid pulses in cycles T+1..T+W (W=user_window, latched at T); the counter saturates at 15, no wrap.
REQ-019 COLLECT->ISSUE after W cycles; W=0 skips COLLECT, so ISSUE occurs at T+1 with nclus=0.
REQ-020 ISSUE lasts exactly one cycle: out_lv1a=1, out_lv1b_req=1, out_nclus=count; all three outputs are registered.
REQ-021 Request-to-lv1a latency: out_lv1b_req high at cycle T+W+1.
REQ-022 ISSUE->HOLD for H cycles (H=user_holdoff, latched at T), then ->IDLE; H=0 goes ISSUE->IDLE directly.
REQ-023 in_clus_valid outside COLLECT is ignored.
REQ-024 in_lv1a while not in IDLE does not restart the FSM and does not change the count.
REQ-025 in_live low in any state: next state IDLE, out_lv1a/out_lv1b_req/out_nclus=0, with no partial request issued.
REQ-026 in_live rising edge (previous-cycle register low, current high): req_cnt=0 and reject_cnt=0 in that cycle; a simultaneous lv1a is still accepted.
REQ-027 req_cnt increments by 1 in each ISSUE cycle and wraps modulo 2^32.
REQ-028 in_ena or user_ena dropping after acceptance does not abort the sequence in progress.
REQ-029 user_window/user_holdoff changes mid-sequence take effect at the next acceptance.

Reset
REQ-030 rst_n low: state=IDLE, all outputs 0, cluster count 0, latched W/H 0, previous-live register 0, all independent of clk.
REQ-031 On rst_n deassertion the FSM stays in IDLE; the first acceptance is possible on the first clk edge with rst_n high.

Configuration
REQ-032 Macro LV1B_REQ_REJECT_CNT_EN: when defined, reject_cnt increments by 1 (wrapping at 2^32) for each in_lv1a with in_live=1 while out_busy=1; when undefined, no counter logic is built and reject_cnt is tied to 0.

Verification
REQ-033 W=4, H=10; lv1a at T, three clus_valid in T+1..T+4 -> out_lv1b_req=out_lv1a=1 at T+5 only, out_nclus=3, out_busy low at T+16, req_cnt=1.
REQ-034 W=20; 18 clus_valid inside the window -> out_nclus=15 (saturated); a clus_valid at T+21 is not counted.
REQ-035 W=0, H=0; lv1a at T -> request at T+1 with nclus=0; a second lv1a at T+2 -> request at T+3, req_cnt=2.
REQ-036 W=4, H=10, macro defined; lv1a at T, T+2, T+8 -> a single request at T+5, reject_cnt=2; macro undefined -> reject_cnt=0.
REQ-037 in_live dropped at T+2 of a W=4 sequence -> no request pulse, IDLE at T+3; live re-rises -> req_cnt=0 and reject_cnt=0.
REQ-038 rst_n asserted mid-HOLD between clk edges -> outputs 0 immediately; after release, lv1a with W=1 -> request 2 cycles later.

Source files
------------

// File: rtl/lv1b_req_gen.sv
// lv1b_req_gen: turns an accepted lv1a into one lv1b request that carries
// the number of clusters seen in a programmable window, then holds off.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_live           run-live level; low aborts to IDLE, rising edge
//                     clears req_cnt / reject_cnt
//   in_ena, user_ena  enables, checked only when an lv1a is accepted
//   in_lv1a           level-1A accept pulse
//   in_clus_valid     one pulse per cluster found
//   user_window       collection window length (cycles), latched on accept
//   user_holdoff      busy cycles after each request, latched on accept
//   out_lv1a          lv1a echo, aligned with out_lv1b_req
//   out_lv1b_req      one-cycle request pulse
//   out_nclus         saturating cluster count, 0 outside the request
//   out_busy          high in COLLECT, ISSUE and HOLD
//   req_cnt           requests issued since the last live rising edge
//   reject_cnt        lv1a pulses seen while busy (only when the macro
//                     LV1B_REQ_REJECT_CNT_EN is defined, else tied to 0)
module lv1b_req_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_live,
    input  logic        in_ena,
    input  logic        in_lv1a,
    input  logic        in_clus_valid,
    input  logic [7:0]  user_window,
    input  logic [15:0] user_holdoff,
    input  logic        user_ena,
    output logic        out_lv1a,
    output logic        out_lv1b_req,
    output logic [3:0]  out_nclus,
    output logic        out_busy,
    output logic [31:0] req_cnt,
    output logic [31:0] reject_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ISSUE,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    // left_q counts down the window in COLLECT and the holdoff in HOLD;
    // it is loaded from user_window on acceptance, so it doubles as the
    // latched window length.
    logic [15:0] left_q, left_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  ncl_q, ncl_d;
    logic        live_q;
    logic        accept;
    logic        live_rise;

    assign accept    = (state_q == IDLE) && in_live && in_ena &&
                       user_ena && in_lv1a;
    assign live_rise = in_live && !live_q;
    assign out_busy  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        hold_d  = hold_q;
        ncl_d   = ncl_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ncl_d  = 4'd0;
                    left_d = {8'd0, user_window};
                    hold_d = user_holdoff;
                    if (user_window == 8'd0) state_d = ISSUE;
                    else                     state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (in_clus_valid && (ncl_q != 4'hF))
                    ncl_d = ncl_q + 4'd1;
                left_d = left_q - 16'd1;
                if (left_q == 16'd1) state_d = ISSUE;
            end
            ISSUE: begin
                left_d = hold_q;
                if (hold_q == 16'd0) state_d = IDLE;
                else                 state_d = HOLD;
            end
            HOLD: begin
                left_d = left_q - 16'd1;
                if (left_q == 16'd1) state_d = IDLE;
            end
        endcase
        // Dropping live kills the sequence before a request can be built.
        if (!in_live) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            left_q       <= '0;
            hold_q       <= '0;
            ncl_q        <= '0;
            live_q       <= 1'b0;
            out_lv1a     <= 1'b0;
            out_lv1b_req <= 1'b0;
            out_nclus    <= '0;
            req_cnt      <= '0;
        end else begin
            state_q      <= state_d;
            left_q       <= left_d;
            hold_q       <= hold_d;
            ncl_q        <= ncl_d;
            live_q       <= in_live;
            out_lv1a     <= (state_d == ISSUE);
            out_lv1b_req <= (state_d == ISSUE);
            out_nclus    <= (state_d == ISSUE) ? ncl_d : 4'd0;
            if (live_rise)
                req_cnt <= '0;
            else if (state_q == ISSUE)
                req_cnt <= req_cnt + 32'd1;
        end
    end

`ifdef LV1B_REQ_REJECT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            reject_cnt <= '0;
        else if (live_rise)
            reject_cnt <= '0;
        else if (in_lv1a && in_live && out_busy)
            reject_cnt <= reject_cnt + 32'd1;
    end
`else
    assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_lv1b_req_gen.sv
// tb_lv1b_req_gen: vector table, directed corner sequences and random
// stimulus checked against a timestamp-based reference model.
module tb_lv1b_req_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_live = 1'b0;
    logic        in_ena = 1'b0;
    logic        in_lv1a = 1'b0;
    logic        in_clus_valid = 1'b0;
    logic [7:0]  user_window = '0;
    logic [15:0] user_holdoff = '0;
    logic        user_ena = 1'b0;
    logic        out_lv1a;
    logic        out_lv1b_req;
    logic [3:0]  out_nclus;
    logic        out_busy;
    logic [31:0] req_cnt;
    logic [31:0] reject_cnt;

    always #5 clk = ~clk;

    lv1b_req_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_live      (in_live),
        .in_ena       (in_ena),
        .in_lv1a      (in_lv1a),
        .in_clus_valid(in_clus_valid),
        .user_window  (user_window),
        .user_holdoff (user_holdoff),
        .user_ena     (user_ena),
        .out_lv1a     (out_lv1a),
        .out_lv1b_req (out_lv1b_req),
        .out_nclus    (out_nclus),
        .out_busy     (out_busy),
        .req_cnt      (req_cnt),
        .reject_cnt   (reject_cnt)
    );

    int total = 0;
    int bad = 0;

    // Reference model: a sequence accepted in cycle tacc is busy in
    // cycles tacc+1 .. tacc+mw+mh+1 and requests in cycle tacc+mw+1.
    int          cyc;
    bit          act;
    int          tacc, mw, mh, mcl;
    logic [31:0] m_req, m_rej;
    bit          m_livep;

    bit          g_uena = 1'b1;
    int          g_w = 0;
    int          g_h = 0;

    task automatic check(input string nm, input logic [31:0] a,
                         input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, a, e, cyc);
        end
    endtask

    function automatic bit e_busy();
        return act && (cyc > tacc) && (cyc <= tacc + mw + mh + 1);
    endfunction

    function automatic bit e_req();
        return act && (cyc == tacc + mw + 1);
    endfunction

    task automatic model_reset();
        act = 1'b0; tacc = 0; mw = 0; mh = 0; mcl = 0;
        m_req = '0; m_rej = '0; m_livep = 1'b0; cyc = 0;
    endtask

    // Check outputs of the current cycle at the falling edge, then drive
    // this cycle's inputs and advance the model past it.
    task automatic cycle(input bit live, input bit ena, input bit lv1a,
                         input bit clus);
        bit b, r;
        @(negedge clk);
        b = e_busy();
        r = e_req();
        check("busy", 32'(out_busy), 32'(b));
        check("lv1b_req", 32'(out_lv1b_req), 32'(r));
        check("lv1a_echo", 32'(out_lv1a), 32'(r));
        check("nclus", 32'(out_nclus), r ? 32'(mcl) : 32'd0);
        check("req_cnt", req_cnt, m_req);
        check("reject_cnt", reject_cnt, m_rej);
        in_live = live; in_ena = ena; in_lv1a = lv1a;
        in_clus_valid = clus; user_ena = g_uena;
        user_window = 8'(g_w); user_holdoff = 16'(g_h);
        if (r) m_req = m_req + 1;
`ifdef LV1B_REQ_REJECT_CNT_EN
        if (live && lv1a && b) m_rej = m_rej + 1;
`endif
        if (act && clus && cyc >= tacc + 1 && cyc <= tacc + mw &&
            mcl < 15)
            mcl++;
        if (!b) act = 1'b0;
        if (!live) act = 1'b0;
        if (live && !m_livep) begin
            m_req = '0; m_rej = '0;
        end
        if (live && ena && g_uena && lv1a && !b) begin
            act = 1'b1; tacc = cyc; mw = g_w; mh = g_h; mcl = 0;
        end
        m_livep = live;
        cyc++;
    endtask

    // Release reset shortly after a rising edge so the next rising edge
    // is the first one seen with rst_n high.
    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit       lv1a;
        bit       clus;
        bit       e_req;
        bit [3:0] e_ncl;
        bit       e_busy;
    } vec_t;

    vec_t tbl[17];

    int seen_at, seen_n, ncl_got;
    bit [7:0] reqmask;

    initial begin
        model_reset();
        for (int k = 0; k < 17; k++) begin
            tbl[k].lv1a   = (k == 0);
            tbl[k].clus   = (k == 1) || (k == 2) || (k == 4);
            tbl[k].e_req  = (k == 5);
            tbl[k].e_ncl  = (k == 5) ? 4'd3 : 4'd0;
            tbl[k].e_busy = (k >= 1) && (k <= 15);
        end

        // reset state
        in_live = 1'b1; in_lv1a = 1'b1; in_ena = 1'b1; user_ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_req", 32'(out_lv1b_req), 32'd0);
        check("rst_req_cnt", req_cnt, 32'd0);
        in_lv1a = 1'b0;
        release_reset();
        repeat (3) cycle(1, 1, 0, 0);

        // basic request, table driven
        g_w = 4; g_h = 10;
        for (int k = 0; k < 17; k++) begin
            cycle(1, 1, tbl[k].lv1a, tbl[k].clus);
            check("tbl_req", 32'(out_lv1b_req), 32'(tbl[k].e_req));
            check("tbl_ncl", 32'(out_nclus), 32'(tbl[k].e_ncl));
            check("tbl_busy", 32'(out_busy), 32'(tbl[k].e_busy));
        end
        check("tbl_req_cnt", req_cnt, 32'd1);

        // saturation at 15, cluster after the window ignored
        g_w = 20; g_h = 0;
        seen_at = -1; seen_n = 0; ncl_got = -1;
        for (int k = 0; k < 25; k++) begin
            cycle(1, 1, k == 0, (k >= 1 && k <= 18) || k == 21);
            if (out_lv1b_req) begin
                seen_at = k; seen_n++; ncl_got = int'(out_nclus);
            end
        end
        check("sat_at", 32'(seen_at), 32'd21);
        check("sat_n", 32'(seen_n), 32'd1);
        check("sat_ncl", 32'(ncl_got), 32'd15);

        // W=0,H=0 back to back, first lv1a on the live rising edge
        g_w = 0; g_h = 0;
        reqmask = '0;
        for (int k = 0; k < 8; k++) begin
            cycle(k != 0, 1, k == 1 || k == 3, 0);
            if (out_lv1b_req) reqmask[k] = 1'b1;
        end
        check("w0_mask", 32'(reqmask), 32'h14);
        check("w0_req_cnt", req_cnt, 32'd2);

        // lv1a while busy: rejected, single request
        g_w = 4; g_h = 10;
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        seen_n = 0; seen_at = -1;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 1, k == 0 || k == 2 || k == 8, k == 3);
            if (out_lv1b_req) begin
                seen_n++; seen_at = k;
            end
        end
        check("rej_n", 32'(seen_n), 32'd1);
        check("rej_at", 32'(seen_at), 32'd5);
`ifdef LV1B_REQ_REJECT_CNT_EN
        check("rej_cnt", reject_cnt, 32'd2);
`else
        check("rej_cnt", reject_cnt, 32'd0);
`endif

        // live drop mid-collect
        g_w = 4; g_h = 3;
        seen_n = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(k != 2 && k != 3, 1, k == 0 || k == 1, 1);
            if (out_lv1b_req) seen_n++;
            if (k == 3) check("drop_idle", 32'(out_busy), 32'd0);
            if (k == 5) begin
                check("drop_req_cnt", req_cnt, 32'd0);
                check("drop_rej_cnt", reject_cnt, 32'd0);
            end
        end
        check("drop_noreq", 32'(seen_n), 32'd0);

        // async reset mid-hold
        g_w = 2; g_h = 10;
        for (int k = 0; k < 7; k++) cycle(1, 1, k == 0, 0);
        check("pre_rst_busy", 32'(out_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(out_busy), 32'd0);
        check("arst_req_cnt", req_cnt, 32'd0);
        check("arst_req", 32'(out_lv1b_req), 32'd0);
        in_lv1a = 1'b0;
        release_reset();
        g_w = 1; g_h = 2;
        seen_at = -1;
        for (int k = 0; k < 6; k++) begin
            cycle(1, 1, k == 0, 0);
            if (out_lv1b_req) seen_at = k;
        end
        check("post_rst_at", 32'(seen_at), 32'd2);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 29) == 0) g_w = $urandom_range(0, 6);
            if ($urandom_range(0, 29) == 0) g_h = $urandom_range(0, 8);
            g_uena = ($urandom_range(0, 9) != 0);
            cycle($urandom_range(0, 59) != 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 9) < 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
